ball_renderer: RTL and testbench
================================

Name: ball_renderer

Overview:
- Pixel-side consumer of the ball position bus (ball x/y outputs). It converts the ball's top-left coordinate into a per-pixel "ball here" flag and colour for the VGA pixel mux.
- It snapshots the position once per frame, during vertical blanking, so a ball moving mid-scan never tears.
- It sits between the ball block and the VGA colour mux, driven by the VGA sync counters.

Parameters:
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in lines
- BALL_SIZE, 7, ball edge length in pixels (square bounding box)
- RESET_X, 270, snapshot X after reset (same as the ball reset position)
- RESET_Y, 450, snapshot Y after reset
- BALL_RGB, 8'hFF, 3-3-2 colour driven while the ball pixel is active

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- pix_en  input  1  pixel-rate enable; the pipeline advances only when this is 1
- hcount  input  10  current pixel column from the VGA sync block
- vcount  input  10  current line from the VGA sync block
- video_on  input  1  visible-area flag, aligned with hcount/vcount
- ball_x  input  10  ball top-left X from the ball block
- ball_y  input  10  ball top-left Y from the ball block
- ball_on  output  1  current delayed pixel is inside the ball shape
- rgb  output  8  BALL_RGB when ball_on is 1, else 8'h00
- video_on_d  output  1  video_on delayed to match ball_on/rgb
- frame_tick  output  1  one-clk pulse on the cycle the snapshot updates

Behaviour:
- Interface: clock is clk; reset is asynchronous and active-high.
- Reset values: snap_x=RESET_X, snap_y=RESET_Y; ball_on=0, rgb=0, video_on_d=0, frame_tick=0; all pipeline stages cleared.
- Snapshot
  - Condition: pix_en=1 and hcount==0 and vcount==SCREEN_H.
  - Action: snap_x<=ball_x, snap_y<=ball_y; frame_tick=1 for that clk only.
  - At no other time does the snapshot change.
- Stage 1 (on pix_en)
  - dx = {1'b0,hcount} - {1'b0,snap_x}, 11-bit signed; dy the same with vcount/snap_y.
  - in_box = video_on and dx[10]==0 and dx<BALL_SIZE and dy[10]==0 and dy<BALL_SIZE.
  - Register in_box, dx[2:0], dy[2:0] and video_on.
- Stage 2 (on pix_en)
  - ball_on <= in_box_q and mask(dy_q)[dx_q].
  - rgb <= ball_on ? BALL_RGB : 0, computed from the same stage-2 inputs so rgb and ball_on are aligned.
  - video_on_d <= video_on_q.
- Latency: exactly 2 pix_en cycles from hcount/vcount to ball_on/rgb/video_on_d. Outputs hold while pix_en=0.
- Boundaries
  - Ball partly past the right or bottom edge (e.g. x=636): draw only the visible columns. The subtraction form means there is no wrap artefact.
  - ball_x/ball_y beyond the screen: nothing is drawn.
  - dx or dy negative: not drawn.
  - Blanking (video_on=0): ball_on is forced to 0.
- Snapshot coinciding with pixel evaluation: the snapshot is taken during blanking, so no visible pixel ever sees a mixed old/new position.
- Reset mid-frame: outputs clear immediately. The snapshot returns to the reset position until the next vblank snapshot.

Optional Feature:
- Macro: ROUND_BALL_EN
- Defined: mask comes from a 7x7 disc ROM, one 7-bit row per line:
  - rows 0 and 6 = 0011100
  - rows 1 and 5 = 0111110
  - rows 2, 3 and 4 = 1111111
- Undefined: mask is all ones, i.e. a solid square, same as the ball's square collision box.
- Latency is 2 in both builds.

Decomposition:
- Shared package breakout_pkg:
  - SCREEN_W, SCREEN_H, BALL_SIZE
  - colour constants (BALL_RGB, BLACK)
  - reset position constants (RESET_X, RESET_Y), shared with the ball block
- One sub-module, ball_shape_rom: combinational 3-bit row in, 7-bit mask out. It contains the ROUND_BALL_EN selection.

Test Plan:
- Reset, ball_x=100/ball_y=100, scan a full frame before any vblank -> ball_on is set only at hcount 270..276 and vcount 450..456, 2 pix_en after those coordinates; frame_tick pulses at (0,480).
- Square build, ball=(100,200) after snapshot -> exactly 49 ball_on pixels per frame; first at (100,200), last at (106,206); rgb=8'hFF only on those pixels.
- Change ball_x from 100 to 300 mid-frame at line 150 -> the current frame still draws at x 100..106; the next frame draws at 300..306; no torn frame.
- Edge clip, ball=(636,476) -> exactly 4x4=16 ball_on pixels per frame; ball=(700,10) -> 0 pixels.
- ROUND_BALL_EN defined, ball=(50,50) -> 37 pixels per frame; (50,50) is off and (52,50) is on.
- Assert reset at line 300 mid-frame -> ball_on and rgb are 0 in the same clk; snapshot returns to (270,450); pix_en held 0 for 10 clk -> outputs frozen.

Source files
------------

// File: rtl/breakout_pkg.sv
// Shared breakout constants: screen geometry, ball size, colours and reset position.
package breakout_pkg;

    localparam int unsigned SCREEN_W  = 640;
    localparam int unsigned SCREEN_H  = 480;
    localparam int unsigned BALL_SIZE = 7;

    localparam logic [9:0] RESET_X = 10'd270;
    localparam logic [9:0] RESET_Y = 10'd450;

    localparam logic [7:0] BALL_RGB = 8'hFF;
    localparam logic [7:0] BLACK    = 8'h00;

    localparam logic [6:0] ROW_SOLID = 7'b1111111;
    localparam logic [6:0] ROW_EMPTY = 7'b0000000;

    typedef logic [6:0] ball_row_t;

endpackage

// File: rtl/ball_renderer_if.sv
// Pixel-side bus between the VGA sync/ball blocks and the ball renderer.
interface ball_renderer_if;
    logic       pix_en;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       video_on;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       ball_on;
    logic [7:0] rgb;
    logic       video_on_d;
    logic       frame_tick;

    modport master (
        output pix_en, hcount, vcount, video_on, ball_x, ball_y,
        input  ball_on, rgb, video_on_d, frame_tick
    );

    modport slave (
        input  pix_en, hcount, vcount, video_on, ball_x, ball_y,
        output ball_on, rgb, video_on_d, frame_tick
    );
endinterface

// File: rtl/ball_shape_rom.sv
// Per-row ball shape mask; ROUND_BALL_EN selects a 7x7 disc, otherwise a solid square.
module ball_shape_rom
    import breakout_pkg::*;
(
    input  logic [2:0] row_i,
    output ball_row_t  mask_o
);

    // Row 7 never lies inside the 7-line box, so it is left empty in both builds.
    always_comb begin
        mask_o = ROW_SOLID;
`ifdef ROUND_BALL_EN
        case (row_i)
            3'd0, 3'd6: mask_o = 7'b0011100;
            3'd1, 3'd5: mask_o = 7'b0111110;
            3'd7:       mask_o = ROW_EMPTY;
            default:    mask_o = ROW_SOLID;
        endcase
`else
        case (row_i)
            3'd7:    mask_o = ROW_EMPTY;
            default: mask_o = ROW_SOLID;
        endcase
`endif
    end

endmodule

// File: rtl/ball_renderer.sv
// Ball pixel renderer: vblank position snapshot plus a 2-stage pix_en pipeline.
// Optional ROUND_BALL_EN build draws a disc instead of a square.
module ball_renderer
    import breakout_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    ball_renderer_if.slave  bus
);

    logic [9:0]  snap_x_q, snap_x_d;
    logic [9:0]  snap_y_q, snap_y_d;
    logic        in_box_q, in_box_d;
    logic [2:0]  dx_q, dx_d;
    logic [2:0]  dy_q, dy_d;
    logic        vid_q, vid_d;
    logic        ball_on_q, ball_on_d;
    logic [7:0]  rgb_q, rgb_d;
    logic        video_on_d_q, video_on_d_d;
    logic        frame_tick_q, frame_tick_d;

    logic        snap_hit_s;
    logic [10:0] dx_s, dy_s;
    logic        in_box_s;
    logic        ball_hit_s;
    ball_row_t   mask_s;
    logic [7:0]  mask_ext_s;

    ball_shape_rom u_shape (
        .row_i  (dy_q),
        .mask_o (mask_s)
    );

    // Next-state logic: snapshot only at the start of the first blanking line.
    always_comb begin
        snap_hit_s = bus.pix_en && (bus.hcount == 10'd0) && (bus.vcount == 10'(SCREEN_H));
        // Subtraction in 11 bits: a negative offset sets bit 10, so no wrap artefacts.
        dx_s       = {1'b0, bus.hcount} - {1'b0, snap_x_q};
        dy_s       = {1'b0, bus.vcount} - {1'b0, snap_y_q};
        in_box_s   = bus.video_on && !dx_s[10] && (dx_s < 11'(BALL_SIZE))
                                  && !dy_s[10] && (dy_s < 11'(BALL_SIZE));
        mask_ext_s = {1'b0, mask_s};
        ball_hit_s = in_box_q && mask_ext_s[dx_q];

        snap_x_d     = snap_x_q;
        snap_y_d     = snap_y_q;
        in_box_d     = in_box_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        vid_d        = vid_q;
        ball_on_d    = ball_on_q;
        rgb_d        = rgb_q;
        video_on_d_d = video_on_d_q;
        frame_tick_d = snap_hit_s;

        if (snap_hit_s) begin
            snap_x_d = bus.ball_x;
            snap_y_d = bus.ball_y;
        end else begin
            snap_x_d = snap_x_q;
            snap_y_d = snap_y_q;
        end

        if (bus.pix_en) begin
            in_box_d     = in_box_s;
            dx_d         = dx_s[2:0];
            dy_d         = dy_s[2:0];
            vid_d        = bus.video_on;
            ball_on_d    = ball_hit_s;
            rgb_d        = ball_hit_s ? BALL_RGB : BLACK;
            video_on_d_d = vid_q;
        end else begin
            in_box_d = in_box_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_x_q     <= RESET_X;
            snap_y_q     <= RESET_Y;
            in_box_q     <= 1'b0;
            dx_q         <= 3'd0;
            dy_q         <= 3'd0;
            vid_q        <= 1'b0;
            ball_on_q    <= 1'b0;
            rgb_q        <= BLACK;
            video_on_d_q <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            snap_x_q     <= snap_x_d;
            snap_y_q     <= snap_y_d;
            in_box_q     <= in_box_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            vid_q        <= vid_d;
            ball_on_q    <= ball_on_d;
            rgb_q        <= rgb_d;
            video_on_d_q <= video_on_d_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.ball_on    = ball_on_q;
    assign bus.rgb        = rgb_q;
    assign bus.video_on_d = video_on_d_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_ball_renderer.sv
// Directed bench for ball_renderer: vector table plus windowed frame scans.
module tb_ball_renderer;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    ball_renderer_if bus ();

    ball_renderer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] h;
        logic [9:0] v;
        logic       von;
        logic       exp_sq;
        logic       exp_rd;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [9:0] h, input logic [9:0] v, input logic von, input logic pe);
        bus.hcount   = h;
        bus.vcount   = v;
        bus.video_on = von;
        bus.pix_en   = pe;
    endtask

    // Hold one pixel for two pix_en cycles so the outputs reflect it.
    task automatic eval(input logic [9:0] h, input logic [9:0] v, input logic von);
        drive(h, v, von, 1'b1);
        tick();
        tick();
    endtask

    task automatic vblank(input logic [9:0] x, input logic [9:0] y);
        bus.ball_x = x;
        bus.ball_y = y;
        drive(10'd0, 10'd480, 1'b0, 1'b1);
        tick();
        check("frame_tick_pulse", bus.frame_tick, 1'b1);
        drive(10'd1, 10'd480, 1'b0, 1'b1);
        tick();
        check("frame_tick_clear", bus.frame_tick, 1'b0);
    endtask

    // Stream a window row-major; output after tick i belongs to pixel i-1.
    task automatic scan(input string name, input int h0, input int h1, input int v0, input int v1,
                        input int exp_cnt, input logic [19:0] exp_first, input logic [19:0] exp_last);
        int w, n, cnt, bad;
        logic [19:0] first, last;
        w = h1 - h0 + 1;
        n = w * (v1 - v0 + 1);
        cnt = 0;
        bad = 0;
        first = 20'hFFFFF;
        last  = 20'hFFFFF;
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                int hh, vv;
                hh = h0 + (i % w);
                vv = v0 + (i / w);
                drive(10'(hh), 10'(vv), (hh < 640) && (vv < 480), 1'b1);
            end else begin
                drive(10'd0, 10'd0, 1'b0, 1'b1);
            end
            tick();
            if (i >= 1) begin
                int ph, pv;
                logic pvon;
                ph = h0 + ((i - 1) % w);
                pv = v0 + ((i - 1) / w);
                pvon = (ph < 640) && (pv < 480);
                if (bus.video_on_d !== pvon) bad++;
                if (bus.rgb !== (bus.ball_on ? 8'hFF : 8'h00)) bad++;
                if (bus.ball_on === 1'b1) begin
                    cnt++;
                    if (first == 20'hFFFFF) first = {10'(ph), 10'(pv)};
                    last = {10'(ph), 10'(pv)};
                end
            end
        end
        check({name, "_count"}, cnt, exp_cnt);
        check({name, "_rgb_vid"}, bad, 0);
        if (exp_cnt > 0) begin
            check({name, "_first"}, first, exp_first);
            check({name, "_last"}, last, exp_last);
        end
    endtask

    initial begin
        logic exp_b;
        tests = 0;
        fails = 0;
        vecs[0] = '{10'd270, 10'd450, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{10'd276, 10'd456, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{10'd273, 10'd453, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{10'd272, 10'd450, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{10'd269, 10'd450, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{10'd277, 10'd453, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{10'd273, 10'd449, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{10'd273, 10'd457, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{10'd100, 10'd100, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{10'd273, 10'd453, 1'b0, 1'b0, 1'b0};

        reset = 1'b1;
        bus.ball_x = 10'd100;
        bus.ball_y = 10'd100;
        drive(10'd5, 10'd5, 1'b0, 1'b1);
        tick();
        tick();
        check("rst_ball_on", bus.ball_on, 1'b0);
        check("rst_rgb", bus.rgb, 8'h00);
        check("rst_video_on_d", bus.video_on_d, 1'b0);
        check("rst_frame_tick", bus.frame_tick, 1'b0);
        reset = 1'b0;

        // Before any vblank the snapshot is the reset position.
        for (int i = 0; i < 10; i++) begin
`ifdef ROUND_BALL_EN
            exp_b = vecs[i].exp_rd;
`else
            exp_b = vecs[i].exp_sq;
`endif
            eval(vecs[i].h, vecs[i].v, vecs[i].von);
            check($sformatf("vec%0d_ball_on", i), bus.ball_on, exp_b);
            check($sformatf("vec%0d_rgb", i), bus.rgb, exp_b ? 8'hFF : 8'h00);
            check($sformatf("vec%0d_video_on_d", i), bus.video_on_d, vecs[i].von);
        end

        // Latency: exactly two pix_en cycles.
        eval(10'd0, 10'd0, 1'b1);
        drive(10'd273, 10'd453, 1'b1, 1'b1);
        tick();
        check("lat_edge1", bus.ball_on, 1'b0);
        drive(10'd0, 10'd0, 1'b1, 1'b1);
        tick();
        check("lat_edge2", bus.ball_on, 1'b1);
        tick();
        check("lat_edge3", bus.ball_on, 1'b0);

        vblank(10'd100, 10'd200);
`ifdef ROUND_BALL_EN
        scan("square", 95, 110, 195, 210, 37, {10'd102, 10'd200}, {10'd104, 10'd206});
`else
        scan("square", 95, 110, 195, 210, 49, {10'd100, 10'd200}, {10'd106, 10'd206});
`endif

        // Ball moves mid-frame; pix_en=0 at the snapshot point must not snapshot.
        bus.ball_x = 10'd300;
        drive(10'd0, 10'd480, 1'b0, 1'b0);
        tick();
        check("no_tick_pix_en0", bus.frame_tick, 1'b0);
`ifdef ROUND_BALL_EN
        scan("old_pos", 95, 110, 195, 210, 37, {10'd102, 10'd200}, {10'd104, 10'd206});
`else
        scan("old_pos", 95, 110, 195, 210, 49, {10'd100, 10'd200}, {10'd106, 10'd206});
`endif
        scan("new_pos_early", 295, 310, 195, 210, 0, 20'd0, 20'd0);
        vblank(10'd300, 10'd200);
`ifdef ROUND_BALL_EN
        scan("new_pos", 295, 310, 195, 210, 37, {10'd302, 10'd200}, {10'd304, 10'd206});
`else
        scan("new_pos", 295, 310, 195, 210, 49, {10'd300, 10'd200}, {10'd306, 10'd206});
`endif

        vblank(10'd636, 10'd476);
`ifdef ROUND_BALL_EN
        scan("clip", 625, 650, 470, 484, 13, {10'd638, 10'd476}, {10'd639, 10'd479});
`else
        scan("clip", 625, 650, 470, 484, 16, {10'd636, 10'd476}, {10'd639, 10'd479});
`endif
        vblank(10'd700, 10'd10);
        scan("offscreen", 610, 639, 5, 20, 0, 20'd0, 20'd0);

        // Reset in the middle of a visible line clears outputs without a clock edge.
        vblank(10'd100, 10'd300);
        eval(10'd103, 10'd303, 1'b1);
        check("pre_reset_on", bus.ball_on, 1'b1);
        reset = 1'b1;
        #1;
        check("mid_reset_ball_on", bus.ball_on, 1'b0);
        check("mid_reset_rgb", bus.rgb, 8'h00);
        tick();
        reset = 1'b0;
        eval(10'd103, 10'd303, 1'b1);
        check("post_reset_old_snap", bus.ball_on, 1'b0);
        eval(10'd273, 10'd453, 1'b1);
        check("post_reset_snap_on", bus.ball_on, 1'b1);

        // pix_en low freezes the outputs.
        drive(10'd0, 10'd0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("freeze%0d_ball_on", i), bus.ball_on, 1'b1);
            check($sformatf("freeze%0d_rgb", i), bus.rgb, 8'hFF);
        end
        bus.pix_en = 1'b1;
        tick();
        tick();
        check("unfreeze_ball_on", bus.ball_on, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
